// File: rtl/register_file_mp.sv
// Multi-port register file with optional zero register, same-cycle write bypass
// and a per-register busy scoreboard for issue/writeback tracking.
module register_file_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NREAD*AW-1:0]  rsel,
  output logic [NREAD*DW-1:0]  rdat,
  output logic [NREAD-1:0]     rbusy,
  input  logic [NWRITE-1:0]    wen,
  input  logic [NWRITE*AW-1:0] wsel,
  input  logic [NWRITE*DW-1:0] wdat,
  input  logic [NWRITE-1:0]    wclr,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_sel,
  output logic [DEPTH-1:0]     busy_vec
);

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;

  logic [DEPTH-1:0] wr_hit, wr_clr;
  logic [DW-1:0]    wr_dat [DEPTH];
  logic [AW-1:0]    ws;
  logic [AW-1:0]    rs;

  // Ports are scanned in ascending order so the highest-indexed writer wins.
  // Writes are masked while reset is held so the bypass cannot leak data.
  always_comb begin
    wr_hit = '0;
    wr_clr = '0;
    ws     = '0;
    for (int r = 0; r < DEPTH; r++) wr_dat[r] = '0;
    for (int w = 0; w < NWRITE; w++) begin
      ws = wsel[w*AW +: AW];
      if (wen[w] && n_rst) begin
        wr_hit[ws] = 1'b1;
        wr_clr[ws] = wclr[w];
        wr_dat[ws] = wdat[w*DW +: DW];
      end
    end
    if (ZERO_REG != 0) begin
      wr_hit[0] = 1'b0;
      wr_clr[0] = 1'b0;
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      if (wr_hit[r]) regs_d[r] = wr_dat[r];
      // A new allocation supersedes a clearing writeback from the old producer.
      if (ZERO_REG != 0 && r == 0)              busy_d[r] = 1'b0;
      else if (set_en && set_sel == AW'(r))     busy_d[r] = 1'b1;
      else if (wr_hit[r] && wr_clr[r])          busy_d[r] = 1'b0;
    end
  end

  always_comb begin
    rdat  = '0;
    rbusy = '0;
    rs    = '0;
    for (int p = 0; p < NREAD; p++) begin
      rs                = rsel[p*AW +: AW];
      rdat[p*DW +: DW]  = regs_q[rs];
      rbusy[p]          = busy_q[rs];
      if (BYPASS != 0 && wr_hit[rs]) begin
        rdat[p*DW +: DW] = wr_dat[rs];
        if (wr_clr[rs]) rbusy[p] = 1'b0;
      end
      if (ZERO_REG != 0 && rs == '0) rdat[p*DW +: DW] = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (default parameters): a driver pushes
// reference-model expectations, a negedge monitor pops and compares.
module tb_register_file_mp;
  localparam int DW = 32, DEPTH = 32, AW = 5, NR = 2, NW = 2;

  logic               clk = 1'b0;
  logic               n_rst;
  logic [NR*AW-1:0]   rsel;
  logic [NR*DW-1:0]   rdat;
  logic [NR-1:0]      rbusy;
  logic [NW-1:0]      wen;
  logic [NW*AW-1:0]   wsel;
  logic [NW*DW-1:0]   wdat;
  logic [NW-1:0]      wclr;
  logic               set_en;
  logic [AW-1:0]      set_sel;
  logic [DEPTH-1:0]   busy_vec;

  register_file_mp dut (
    .clk(clk), .n_rst(n_rst), .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
    .wen(wen), .wsel(wsel), .wdat(wdat), .wclr(wclr),
    .set_en(set_en), .set_sel(set_sel), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d0, d1;
    logic [1:0]  rb;
    logic [31:0] bv;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, pushed = 0, popped = 0;

  // Reference model: register contents and busy flags as plain arrays.
  logic [31:0] m_mem  [DEPTH];
  bit          m_busy [DEPTH];

  bit          c_en  [NW];
  logic [4:0]  c_sel [NW];
  logic [31:0] c_dat [NW];
  bit          c_clr [NW];
  bit          c_se;
  logic [4:0]  c_ss;

  function automatic int winner(input logic [4:0] s);
    if (s == 5'd0) return -1;
    for (int w = NW - 1; w >= 0; w--)
      if (c_en[w] && c_sel[w] == s) return w;
    return -1;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < DEPTH; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int r = 1; r < DEPTH; r++) begin
      int w;
      w = winner(5'(r));
      if (w >= 0) m_mem[r] = c_dat[w];
      if (c_se && c_ss == 5'(r))       m_busy[r] = 1'b1;
      else if (w >= 0 && c_clr[w])     m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] s);
    int w;
    w = winner(s);
    if (s == 5'd0) return 32'd0;
    if (w >= 0) return c_dat[w];
    return m_mem[s];
  endfunction

  function automatic logic exp_rb(input logic [4:0] s);
    int w;
    w = winner(s);
    return m_busy[s] && !(w >= 0 && c_clr[w]);
  endfunction

  task automatic cycle(input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] we, input logic [4:0] w0, input logic [4:0] w1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] wc,
                       input logic se, input logic [4:0] ss, input bit mid_rst);
    exp_t e;
    rsel = {r1, r0}; wen = we; wsel = {w1, w0}; wdat = {d1, d0};
    wclr = wc; set_en = se; set_sel = ss;
    c_en[0] = we[0]; c_en[1] = we[1]; c_sel[0] = w0; c_sel[1] = w1;
    c_dat[0] = d0; c_dat[1] = d1; c_clr[0] = wc[0]; c_clr[1] = wc[1];
    c_se = se; c_ss = ss;
    if (mid_rst) begin
      #2;
      n_rst = 1'b0;
    end
    if (!n_rst) begin
      model_clear();
      e.d0 = '0; e.d1 = '0; e.rb = '0; e.bv = '0;
    end else begin
      e.d0 = exp_rd(r0);
      e.d1 = exp_rd(r1);
      e.rb = {exp_rb(r1), exp_rb(r0)};
      for (int r = 0; r < DEPTH; r++) e.bv[r] = m_busy[r];
    end
    q.push_back(e);
    pushed++;
    @(posedge clk);
    if (n_rst) model_step();
    #1;
  endtask

  function automatic logic [4:0] rnd_sel();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rnd_cycle();
    cycle(rnd_sel(), rnd_sel(), 2'($urandom_range(0, 3)), rnd_sel(), rnd_sel(),
          $urandom, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), rnd_sel(), 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        popped++;
        check("rdat0", rdat[31:0], e.d0);
        check("rdat1", rdat[63:32], e.d1);
        check("rbusy", {30'd0, rbusy}, {30'd0, e.rb});
        check("busy_vec", busy_vec, e.bv);
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    rsel = '0; wen = '0; wsel = '0; wdat = '0; wclr = '0; set_en = 1'b0; set_sel = '0;
    model_clear();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rnd_cycle();
    n_rst = 1'b1;
    for (int r = 0; r < DEPTH; r += 2)
      cycle(5'(r), 5'(r + 1), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    // basic write with same-cycle bypass, then registered read
    cycle(5'd0, 5'd5, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    cycle(5'd5, 5'd5, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    // zero register ignores writes and allocation
    cycle(5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'h12345678, 32'd0, 2'b01, 1'b1, 5'd0, 1'b0);
    cycle(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    // write conflict on busy reg 7: port1 data and its wclr=0 win
    cycle(5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b1, 5'd7, 1'b0);
    cycle(5'd7, 5'd0, 2'b11, 5'd7, 5'd7, 32'h1, 32'h2, 2'b01, 1'b0, 5'd0, 1'b0);
    cycle(5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    // busy scoreboard on reg 9: set, clearing write, set beats clear
    cycle(5'd9, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b1, 5'd9, 1'b0);
    cycle(5'd9, 5'd9, 2'b01, 5'd9, 5'd0, 32'hA5A5A5A5, 32'd0, 2'b01, 1'b0, 5'd0, 1'b0);
    cycle(5'd9, 5'd9, 2'b10, 5'd0, 5'd9, 32'd0, 32'h5A5A5A5A, 2'b10, 1'b1, 5'd9, 1'b0);
    cycle(5'd9, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    // asynchronous reset mid-cycle with pending write and set
    cycle(5'd3, 5'd3, 2'b01, 5'd3, 5'd0, 32'hCAFEF00D, 32'd0, 2'b00, 1'b1, 5'd3, 1'b1);
    n_rst = 1'b1;
    cycle(5'd3, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 500; i++) rnd_cycle();
    repeat (3) @(posedge clk);
    check("drained", popped, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port general-purpose register file: NREAD combinational read ports and NWRITE synchronous write ports.
- Optional hard-wired zero register and optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: set when an instruction allocates a destination, cleared when its result is written back.
- Sits between decode/issue (reads, busy set) and writeback (writes) in the pipelined datapath. Replaces the single-write, dual-read file.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of 2, at least 2.
- NREAD, 2, number of read ports.
- NWRITE, 2, number of write ports.
- ZERO_REG, 1, 1 = register 0 always reads 0, is never written, and is never busy.
- BYPASS, 1, 1 = a same-cycle write is visible on the read data and busy outputs.
- AW, $clog2(DEPTH), derived; select width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- rsel  input  NREAD*AW  read selects, port p at bits [p*AW +: AW].
- rdat  output  NREAD*DW  read data, port p at bits [p*DW +: DW].
- rbusy  output  NREAD  busy flag of the register selected on each read port.
- wen  input  NWRITE  write enable per write port.
- wsel  input  NWRITE*AW  write selects.
- wdat  input  NWRITE*DW  write data.
- wclr  input  NWRITE  when set together with wen, the write also clears the target's busy bit.
- set_en  input  1  allocate destination: mark register busy.
- set_sel  input  AW  register to mark busy.
- busy_vec  output  DEPTH  registered busy bits, one per register.

Behaviour:
- Reset (n_rst low, asynchronous): all registers 0, all busy bits 0. Therefore rdat = 0, rbusy = 0, busy_vec = 0 while reset is held and in the first cycle after release. Reset asserted mid-operation discards any pending write or set in that cycle.
- Write: on a rising edge, for each port w with wen[w]=1, reg[wsel[w]] <= wdat[w].
  - Two or more ports targeting the same register: the highest-indexed port wins, for both data and wclr.
  - ZERO_REG=1 and wsel=0: the write is ignored and reg[0] stays 0.
- Read: combinational. rdat[p] = reg[rsel[p]], with 0 returned for register 0 when ZERO_REG=1.
  - BYPASS=1 and some port w has wen[w]=1 with wsel[w]==rsel[p] (nonzero if ZERO_REG): rdat[p] = wdat of the winning port.
  - BYPASS=0: the new value is visible from the next cycle.
- Busy next-state, per register r, evaluated in priority order:
  1. ZERO_REG=1 and r=0: stays 0.
  2. set_en=1 and set_sel=r: 1. A set wins over a simultaneous clearing write to the same register, because a new producer supersedes the old one.
  3. The winning write to r has wclr=1: 0.
  4. Otherwise: hold.
- A write with wclr=0 never changes busy. A write to a non-busy register with wclr=1 leaves it at 0.
- rbusy[p] = busy[rsel[p]].
  - BYPASS=1: additionally forced to 0 when a same-cycle winning write to that register has wclr=1. Same-cycle set_en does not raise rbusy; it takes effect next cycle.
  - BYPASS=0: registered value only.
- busy_vec is always the registered state, with no bypass.
- Latency: write to read is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0. Set to busy is 1 cycle.
- No overflow or wrap conditions exist. Selects are AW bits wide, so all select values are in range.

Test Plan:
- Reset: hold n_rst low, drive random selects -> all rdat = 0, rbusy = 0, busy_vec = 0. Release, then read all 32 registers -> all 0.
- Basic write/read, BYPASS=1: wen[0]=1, wsel=5, wdat=0xDEADBEEF, rsel[1]=5 in the same cycle -> rdat[1]=0xDEADBEEF immediately and after the edge. With BYPASS=0 -> old value (0) during the cycle, 0xDEADBEEF next cycle.
- Zero register: write 0x12345678 to register 0, and set_en with set_sel=0 -> rdat=0, busy_vec[0]=0 on all later cycles.
- Write conflict: port0 writes reg 7 = 0x1, port1 writes reg 7 = 0x2 in the same cycle -> reg 7 reads 0x2. Port0 wclr=1, port1 wclr=0 on busy reg 7 -> reg 7 stays busy.
- Scoreboard: set_en, set_sel=9 -> busy_vec[9]=1 next cycle. Then write reg 9 with wclr=1 and rsel=9 -> rbusy=0 that cycle (BYPASS=1) and busy_vec[9]=0 next cycle. Set and clearing write to reg 9 in the same cycle -> busy_vec[9]=1 next cycle.
- Reset mid-operation: assert n_rst low between edges while wen=1 and set_en=1 -> outputs go to 0 asynchronously. After release, the target register is 0 and not busy.
